mux_rr_stream: RTL
==================

Name: mux_rr_stream

Overview:
- Parametrised successor to the 16-bit 2:1 datapath mux.
- N-channel, W-bit stream multiplexer with per-channel valid/ready handshake and a single registered output stage.
- Two modes: fixed select (the classic mux, select driven externally) and round-robin arbitration.
- Sits between multiple producers (register-file read ports, memory return, immediate path) and a single consumer stage of the 16-bit core.

Parameters:
- WIDTH, 16, data width in bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS) with a minimum of 1, width of the select and channel-id fields (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_chan  output  SEL_W  registered index of the source channel.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
- Transfer rules:
  - A transfer on channel i occurs when in_valid[i] && in_ready[i] at a rising clk.
  - An output transfer occurs when out_valid && out_ready.
- load = !out_valid || out_ready; the output register may accept new data this cycle.
- Grant, combinational:
  - mode=0: grant=sel if sel<CHANNELS, else no grant.
  - mode=1: grant = first i with in_valid[i], searching from rr_ptr upward and wrapping modulo CHANNELS; no grant if all valids are low.
- in_ready[i] = load && grant_valid && (grant==i). All other in_ready bits are 0, so at most one in_ready bit is high per cycle.
- mode=0 with a valid sel: in_ready[sel] = load, independent of in_valid[sel].
- On an input transfer: out_data <= in_data of the granted channel, out_chan <= grant, out_valid <= 1.
- If load is high and no input transfer occurs: out_valid <= 0. out_data and out_chan hold their values.
- If !load: all output registers hold (backpressure).
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle while out_ready=1.
- rr_ptr:
  - In mode=1, on a transfer, rr_ptr <= (grant+1) mod CHANNELS; wrap from CHANNELS-1 to 0.
  - rr_ptr does not change in mode=0 or when no transfer occurs.
- Simultaneous out_ready=1 and a new input transfer: the new word replaces the old word in the same cycle, with no bubble.
- A mode or sel change takes effect on the next grant evaluation. A word already registered is unaffected.
- Non-power-of-two CHANNELS: sel values >= CHANNELS grant nothing, and out_valid deasserts after the current word drains.
- Reset asserted mid-transfer: the output word is discarded immediately and in_ready drops to 0 asynchronously.

Decomposition:
- Shared package mux_pkg holds:
  - mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a clog2-with-minimum-1 function, reused by future mux variants.
- One sub-module: rr_pick, a combinational rotating priority encoder (in: valid vector, pointer; out: grant, grant_valid).
- The output register and pointer logic stay in the top module.

Test Plan:
- Reset: with rst_n=0, force in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0. After release, first grant is channel 0 (rr_ptr=0).
- Fixed mode, back-to-back: mode=0, sel=2, in_data ch2 = 16'hFFFF, other channels 16'h0000, all valid, out_ready=1 -> one cycle later out_data=16'hFFFF, out_chan=2. in_ready=4'b0100 every cycle.
- Round-robin fairness: mode=1, all four channels valid, channel i data = 16'h1000+i, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with matching data.
- Round-robin skip and wrap: mode=1, rr_ptr=3, in_valid=4'b0101 -> grant 0, then 2, then 0. Channels 1 and 3 never see in_ready.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_chan stable, in_ready=0, rr_ptr unchanged. When out_ready returns to 1, the next word loads in that same cycle.
- Out-of-range select with CHANNELS=3: mode=0, sel=3 -> in_ready=0. After the pending word drains, out_valid=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer family: mode encodings and
// width helpers reused by later mux variants.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, never below 1, so a 1- or 2-entry index still gets a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_stream_rr_pick.sv
// Rotating priority encoder: the first asserted valid at or above ptr wins,
// wrapping modulo CHANNELS.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] idx;

  // ptr < CHANNELS and i < CHANNELS, so one conditional subtract wraps the sum.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(i);
      if (sum >= (SEL_W+1)'(CHANNELS)) begin
        sum = sum - (SEL_W+1)'(CHANNELS);
      end
      idx = sum[SEL_W-1:0];
      if (!grant_valid && valid[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel stream multiplexer with fixed-select or round-robin arbitration
// and a single registered output stage.
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] chan_data [CHANNELS];
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_grant_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load;
  logic             xfer;
  logic [SEL_W-1:0] ptr_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .valid       (in_valid),
    .ptr         (rr_ptr),
    .grant       (rr_grant),
    .grant_valid (rr_grant_valid)
  );

  // Grant selection; ready is gated by reset so it drops as soon as reset asserts.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end else if (32'(sel) < CHANNELS) begin
      grant       = sel;
      grant_valid = 1'b1;
    end

    load     = !out_valid || out_ready;
    in_ready = '0;
    if (rst_n && load && grant_valid) begin
      in_ready = CHANNELS'(1) << grant;
    end
    xfer = |(in_valid & in_ready);

    ptr_next = grant + SEL_W'(1);
    if (32'(grant) == CHANNELS - 1) begin
      ptr_next = '0;
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) begin
        if (xfer) begin
          out_valid <= 1'b1;
          out_data  <= chan_data[grant];
          out_chan  <= grant;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (xfer && mode == MODE_RR) begin
        rr_ptr <= ptr_next;
      end
    end
  end

endmodule
